spi_hk_reader: RTL

Consumes the level interrupt request produced by the arm/go/1 ms-tick request generator and turns each request into a burst of SPI mode-0 read frames to a housekeeping ADC. Captured words sit in a small register bank that the host reads back. The block reports busy/done, keeps a completed-sequence count, and counts requests dropped while a burst is in progress.

---
 rtl/spi_hk_reader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spi_hk_reader.sv
// Housekeeping ADC reader: each rising edge of int_req triggers a burst of SPI
// mode-0 read frames. Captured words go into a small bank that the host reads back.
module spi_hk_reader #(
  parameter int unsigned CLK_DIV   = 50,
  parameter int unsigned WORD_BITS = 16,
  parameter int unsigned NUM_WORDS = 4,
  parameter logic [31:0] CMD_BASE  = 32'h0000_8000,
  parameter int unsigned GAP_CYC   = 20,
  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 int_req,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  input  logic                 miso,
  input  logic [AW-1:0]        rd_addr,
  output logic [WORD_BITS-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          seq_count,
  output logic [7:0]           overrun_cnt
);

  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned BW      = $clog2(WORD_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_END, S_GAP, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        div_cnt, div_nxt;
  logic [BW-1:0]        rise_cnt, rise_nxt;
  logic [AW-1:0]        idx, idx_nxt;
  logic [WORD_BITS-1:0] tx_sh, tx_nxt;
  logic [WORD_BITS-1:0] rx_sh, rx_nxt;
  logic [WORD_BITS-1:0] load_cmd;
  logic                 sclk_nxt, cs_n_nxt;
  logic [15:0]          seq_nxt;
  logic [7:0]           ovr_nxt;
  logic                 int_d1;
  logic                 req_rise;
  logic [WORD_BITS-1:0] bank [NUM_WORDS];

  assign req_rise = int_req & ~int_d1;
  // The MSB of the command shift register is the registered MOSI line.
  assign mosi     = tx_sh[WORD_BITS-1];

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    rise_nxt  = rise_cnt;
    idx_nxt   = idx;
    tx_nxt    = tx_sh;
    rx_nxt    = rx_sh;
    sclk_nxt  = sclk;
    cs_n_nxt  = cs_n;
    seq_nxt   = seq_count;
    ovr_nxt   = overrun_cnt;
    load_cmd  = '0;

    if (req_rise && state != S_IDLE && overrun_cnt != 8'hFF)
      ovr_nxt = overrun_cnt + 8'd1;

    case (state)
      S_IDLE: begin
        if (req_rise) begin
          load_cmd  = WORD_BITS'(CMD_BASE);
          state_nxt = S_SETUP;
          idx_nxt   = '0;
          div_nxt   = '0;
          cs_n_nxt  = 1'b0;
          sclk_nxt  = 1'b0;
          tx_nxt    = load_cmd;
        end
      end
      S_SETUP: begin
        if (div_cnt == CW'(CLK_DIV - 1)) begin
          state_nxt = S_SHIFT;
          div_nxt   = '0;
          sclk_nxt  = 1'b1;
          rise_nxt  = BW'(1);
          rx_nxt    = {rx_sh[WORD_BITS-2:0], miso};
        end else begin
          div_nxt = div_cnt + CW'(1);
        end
      end
      S_SHIFT: begin
        if (div_cnt == CW'(CLK_DIV - 1)) begin
          div_nxt = '0;
          if (sclk) begin
            sclk_nxt = 1'b0;
            tx_nxt   = {tx_sh[WORD_BITS-2:0], 1'b0};
          end else if (rise_cnt == BW'(WORD_BITS)) begin
            // final low half-period was the hold time
            state_nxt = S_END;
            cs_n_nxt  = 1'b1;
            tx_nxt    = '0;
          end else begin
            sclk_nxt = 1'b1;
            rise_nxt = rise_cnt + BW'(1);
            rx_nxt   = {rx_sh[WORD_BITS-2:0], miso};
          end
        end else begin
          div_nxt = div_cnt + CW'(1);
        end
      end
      S_END: begin
        div_nxt = '0;
        if (idx == AW'(NUM_WORDS - 1)) begin
          state_nxt = S_DONE;
          seq_nxt   = seq_count + 16'd1;
        end else begin
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (div_cnt == CW'(GAP_CYC - 1)) begin
          load_cmd  = WORD_BITS'(CMD_BASE + 32'(idx) + 32'd1);
          state_nxt = S_SETUP;
          div_nxt   = '0;
          idx_nxt   = idx + AW'(1);
          cs_n_nxt  = 1'b0;
          tx_nxt    = load_cmd;
        end else begin
          div_nxt = div_cnt + CW'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      rise_cnt    <= '0;
      idx         <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      sclk        <= 1'b0;
      cs_n        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      seq_count   <= '0;
      overrun_cnt <= '0;
      int_d1      <= 1'b0;
      rd_data     <= '0;
      bank        <= '{default: '0};
    end else begin
      state       <= state_nxt;
      div_cnt     <= div_nxt;
      rise_cnt    <= rise_nxt;
      idx         <= idx_nxt;
      tx_sh       <= tx_nxt;
      rx_sh       <= rx_nxt;
      sclk        <= sclk_nxt;
      cs_n        <= cs_n_nxt;
      busy        <= (state_nxt != S_IDLE);
      done        <= (state_nxt == S_DONE);
      seq_count   <= seq_nxt;
      overrun_cnt <= ovr_nxt;
      int_d1      <= int_req;
      rd_data     <= bank[rd_addr];
      if (state == S_END)
        bank[idx] <= rx_sh;
    end
  end

endmodule
